ws2812_scheduler: RTL and testbench

- Frame controller for the WS2812 LED chain: owns a NUM_LEDS-deep 24-bit pixel buffer and shares write access between two requesters with fixed priority (A = system status, B = core activity).
- On each refresh tick it streams the buffer, pixel 0 first, to the downstream bit-serial encoder over a valid/ready handshake.
- After the last pixel it holds a latch gap.
- Sits between status logic and the single WS2812 output encoder.

---
 rtl/ws2812_scheduler_if.sv | 26 ++
 rtl/ws2812_scheduler.sv | 112 +++++++++++
 tb/tb_ws2812_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ws2812_scheduler_if.sv
// ws2812_scheduler_if: requester write ports, pixel stream and status of the WS2812 frame scheduler
interface ws2812_scheduler_if;
  logic        req_a;
  logic [7:0]  idx_a;
  logic [23:0] color_a;
  logic        grant_a;
  logic        req_b;
  logic [7:0]  idx_b;
  logic [23:0] color_b;
  logic        grant_b;
  logic        px_valid;
  logic [23:0] px_data;
  logic        px_ready;
  logic        busy;
  logic        frame_done;
  logic        err_oor;
  logic        overrun;
  modport master (
    output req_a, idx_a, color_a, req_b, idx_b, color_b, px_ready,
    input  grant_a, grant_b, px_valid, px_data, busy, frame_done, err_oor, overrun
  );
  modport slave (
    input  req_a, idx_a, color_a, req_b, idx_b, color_b, px_ready,
    output grant_a, grant_b, px_valid, px_data, busy, frame_done, err_oor, overrun
  );
endinterface

// File: rtl/ws2812_scheduler.sv
// ws2812_scheduler: pixel buffer with A>B write arbitration, streamed to the WS2812 encoder on each refresh tick.
// Define WS2812_DIRTY_ONLY_EN to skip frames when nothing was written since the last one.
module ws2812_scheduler #(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_FRE    = 27_000_000,
  parameter int REFRESH_HZ = 50,
  parameter int LATCH_CYC  = 2700
) (
  input logic clk,
  input logic reset,
  ws2812_scheduler_if.slave io
);
  localparam int PER = CLK_FRE / REFRESH_HZ;
  localparam int IW  = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  localparam int CW  = PER > 1 ? $clog2(PER) : 1;
  localparam int LW  = LATCH_CYC > 1 ? $clog2(LATCH_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
  state_t state, state_n;
  logic [23:0] pix [NUM_LEDS];
  logic [CW-1:0] cnt;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [IW-1:0] send_idx, send_idx_n;
  logic [23:0] px_data_n, wr_color;
  logic [7:0] wr_idx;
  logic pending, pending_n, px_valid_n, tick, go, hs, last, wr, wr_ok, send_ok;
  assign tick     = cnt == CW'(PER - 1);
  assign go       = tick || pending;
  assign hs       = io.px_valid && io.px_ready;
  assign last     = send_idx == IW'(NUM_LEDS - 1);
  assign wr       = io.req_a || io.req_b;
  assign wr_idx   = io.req_a ? io.idx_a : io.idx_b;
  assign wr_color = io.req_a ? io.color_a : io.color_b;
  assign wr_ok    = wr && ({1'b0, wr_idx} < 9'(NUM_LEDS));
  assign io.frame_done = state == LATCH && lcnt == LW'(LATCH_CYC - 1);
`ifdef WS2812_DIRTY_ONLY_EN
  logic dirty;
  // a write landing on the frame-start edge keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) dirty <= 1'b0;
    else if (wr_ok) dirty <= 1'b1;
    else if (state == IDLE && go) dirty <= 1'b0;
  end
  assign send_ok = dirty;
`else
  assign send_ok = 1'b1;
`endif
  always_comb begin
    state_n    = state;
    send_idx_n = send_idx;
    lcnt_n     = lcnt;
    px_valid_n = io.px_valid;
    px_data_n  = io.px_data;
    pending_n  = (tick && state != IDLE) ? 1'b1 : pending;
    case (state)
      IDLE: if (go) begin
        pending_n = 1'b0;
        if (send_ok) begin
          state_n    = SEND;
          send_idx_n = '0;
          px_data_n  = pix[0];
          px_valid_n = 1'b1;
        end
      end
      SEND: if (hs) begin
        if (last) begin
          px_valid_n = 1'b0;
          lcnt_n     = '0;
          state_n    = LATCH;
        end else begin
          send_idx_n = send_idx + 1'b1;
          px_data_n  = pix[send_idx + 1'b1];
        end
      end
      LATCH: begin
        state_n = io.frame_done ? IDLE : LATCH;
        lcnt_n  = io.frame_done ? lcnt : lcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lcnt        <= '0;
      send_idx    <= '0;
      pending     <= 1'b0;
      io.overrun  <= 1'b0;
      io.px_valid <= 1'b0;
      io.px_data  <= '0;
      io.busy     <= 1'b0;
      io.grant_a  <= 1'b0;
      io.grant_b  <= 1'b0;
      io.err_oor  <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) pix[i] <= '0;
    end else begin
      state       <= state_n;
      cnt         <= tick ? '0 : cnt + 1'b1;
      lcnt        <= lcnt_n;
      send_idx    <= send_idx_n;
      pending     <= pending_n;
      io.overrun  <= io.overrun || (tick && state != IDLE && pending);
      io.px_valid <= px_valid_n;
      io.px_data  <= px_data_n;
      io.busy     <= state_n != IDLE;
      io.grant_a  <= io.req_a;
      io.grant_b  <= !io.req_a && io.req_b;
      io.err_oor  <= wr && !wr_ok;
      if (wr_ok) pix[wr_idx[IW-1:0]] <= wr_color;
    end
  end
endmodule

// File: tb/tb_ws2812_scheduler.sv
// tb_ws2812_scheduler: scoreboard bench; stimulus queues expected pixel words and grant events, a monitor pops and compares.
module tb_ws2812_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  int start_cyc = 0, last_cyc = 0, widx = 0;
  int s1, d1, d2, d3, d4, d5, d6, d7;
  logic [23:0] exp_q[$];
  logic [2:0]  gq[$];
  logic [23:0] hold;
  ws2812_scheduler_if io();
  ws2812_scheduler #(.NUM_LEDS(4), .CLK_FRE(1000), .REFRESH_HZ(10), .LATCH_CYC(20)) dut (
    .clk(clk), .reset(reset), .io(io)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (reset) widx = 0;
    else begin
      if (io.px_valid && io.px_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {8'h0, io.px_data}, 32'hFFFF_FFFF);
        else chk("px_word", {8'h0, io.px_data}, {8'h0, exp_q.pop_front()});
        if (widx == 0) start_cyc = cyc;
        if (widx == 3) last_cyc = cyc;
        widx = (widx + 1) % 4;
      end
      if (io.grant_a || io.grant_b || io.err_oor) begin
        if (gq.size() == 0) chk("unexpected_grant", {29'h0, io.grant_a, io.grant_b, io.err_oor}, 32'hFFFF_FFFF);
        else chk("grant_event", {29'h0, io.grant_a, io.grant_b, io.err_oor}, {29'h0, gq.pop_front()});
      end
    end
  end

  task automatic push_frame(input logic [23:0] w0, w1, w2, w3);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    exp_q.push_back(w3);
  endtask

  task automatic wr_a(input logic [7:0] idx, input logic [23:0] col, input logic err);
    io.req_a = 1'b1;
    io.idx_a = idx;
    io.color_a = col;
    gq.push_back({2'b10, err});
    @(negedge clk);
    io.req_a = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!io.px_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("px_valid_timeout", {31'h0, io.px_valid}, 1);
  endtask

  task automatic wait_done(output int d);
    int n = 0;
    while (!io.frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_timeout", {31'h0, io.frame_done}, 1);
    d = cyc;
    @(negedge clk);
  endtask

  initial begin
    io.req_a = 0; io.req_b = 0; io.idx_a = 0; io.idx_b = 0;
    io.color_a = 0; io.color_b = 0; io.px_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_px_valid", {31'h0, io.px_valid}, 0);
    chk("rst_px_data", {8'h0, io.px_data}, 0);
    chk("rst_busy", {31'h0, io.busy}, 0);
    chk("rst_grants", {29'h0, io.grant_a, io.grant_b, io.err_oor}, 0);
    chk("rst_frame_done", {31'h0, io.frame_done}, 0);
    chk("rst_overrun", {31'h0, io.overrun}, 0);
    reset = 1'b0;
    wr_a(0, 24'hFF0000, 0);
    wr_a(3, 24'h0000FF, 0);
    push_frame(24'hFF0000, 24'h0, 24'h0, 24'h0000FF);
    wait_done(d1);
    chk("latch_gap", d1 - last_cyc, 20);
    chk("burst_len", last_cyc - start_cyc, 3);
    s1 = start_cyc;
    io.req_a = 1; io.idx_a = 1; io.color_a = 24'h00AA00;
    io.req_b = 1; io.idx_b = 2; io.color_b = 24'h000055;
    gq.push_back(3'b100);
    gq.push_back(3'b010);
    @(negedge clk);
    io.req_a = 0;
    chk("ab_first_a", {30'h0, io.grant_a, io.grant_b}, 2'b10);
    @(negedge clk);
    io.req_b = 0;
    chk("ab_then_b", {30'h0, io.grant_a, io.grant_b}, 2'b01);
    push_frame(24'hFF0000, 24'h00AA00, 24'h000055, 24'h0000FF);
    wait_done(d2);
    chk("tick_period", start_cyc - s1, 100);
    wr_a(0, 24'hFF0000, 0);
    push_frame(24'hFF0000, 24'h00AA00, 24'h222222, 24'h0000FF);
    wait_valid(150);
    @(negedge clk);
    io.px_ready = 0;
    hold = io.px_data;
    chk("stall_word1", {8'h0, hold}, 32'h00AA00);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        io.req_a = 1; io.idx_a = 1; io.color_a = 24'h111111; gq.push_back(3'b100);
      end else if (i == 1) begin
        io.idx_a = 2; io.color_a = 24'h222222; gq.push_back(3'b100);
      end else io.req_a = 0;
      chk("stall_valid", {31'h0, io.px_valid}, 1);
      chk("stall_data", {8'h0, io.px_data}, {8'h0, hold});
      @(negedge clk);
    end
    io.px_ready = 1;
    wait_done(d3);
    wr_a(5, 24'h123456, 1);
    chk("oor_grant_err", {30'h0, io.grant_a, io.err_oor}, 2'b11);
    push_frame(24'hFF0000, 24'h111111, 24'h222222, 24'h0000FF);
    wait_done(d4);
    wr_a(0, 24'hFF0000, 0);
    io.px_ready = 0;
    push_frame(24'hFF0000, 24'h111111, 24'h222222, 24'h0000FF);
    push_frame(24'hFF0000, 24'h111111, 24'h222222, 24'h0000FF);
    wait_valid(150);
    for (int i = 0; i < 240; i++) begin
      if (i == 10) begin
        io.req_a = 1; io.idx_a = 0; io.color_a = 24'hFF0000; gq.push_back(3'b100);
      end else if (i == 11) io.req_a = 0;
      if (i == 150) begin
        chk("pending_no_overrun", {31'h0, io.overrun}, 0);
        chk("stall_busy", {31'h0, io.busy}, 1);
      end
      if (i == 239) chk("overrun_set", {31'h0, io.overrun}, 1);
      @(negedge clk);
    end
    io.px_ready = 1;
    wait_done(d5);
    wait_done(d6);
    chk("pending_restart", start_cyc - d5, 2);
    chk("overrun_sticky", {31'h0, io.overrun}, 1);
    io.px_ready = 0;
    wr_a(0, 24'hFF0000, 0);
    wait_valid(150);
    chk("hold_word0", {8'h0, io.px_data}, 32'hFF0000);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_px_valid", {31'h0, io.px_valid}, 0);
    chk("midrst_busy", {31'h0, io.busy}, 0);
    chk("midrst_overrun", {31'h0, io.overrun}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    io.px_ready = 1;
`ifdef WS2812_DIRTY_ONLY_EN
    begin
      int nv = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (io.px_valid) nv++;
      end
      chk("dirty_no_frames", nv, 0);
    end
    wr_a(2, 24'h00FF00, 0);
    push_frame(24'h0, 24'h0, 24'h00FF00, 24'h0);
`else
    push_frame(24'h0, 24'h0, 24'h0, 24'h0);
`endif
    wait_done(d7);
    @(negedge clk);
    chk("words_left", exp_q.size(), 0);
    chk("grants_left", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
